// File: rtl/brick_mem_arbiter.sv
// rtl/brick_mem_arbiter.sv - brick health memory arbiter serving hit, probe and draw requesters
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin probe/draw arbitration.
module brick_mem_arbiter #(
    parameter int COLS         = 20,
    parameter int ROWS         = 8,
    parameter int TOTAL_BRICKS = 160
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       probe_req,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic       probe_ack,
    input  logic       draw_req,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic       draw_ack,
    output logic [1:0] rd_health,
    input  logic       hit_req,
    input  logic [9:0] hit_x,
    input  logic [9:0] hit_y,
    output logic       hit_ack,
    output logic [7:0] mem_addr,
    input  logic [1:0] mem_rdata,
    output logic [1:0] mem_wdata,
    output logic       mem_we,
    output logic [7:0] bricks_left,
    output logic       all_cleared
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_RESP, ST_WRITE} state_t;
    typedef enum logic [1:0] {SRC_PROBE, SRC_DRAW, SRC_HIT} src_t;

    state_t     state_q, state_d;
    src_t       src_q, src_d;
    logic [7:0] addr_q, addr_d;
    logic       in_range_q, in_range_d;
    logic [1:0] health_q, health_d;
    logic [7:0] bricks_q, bricks_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic       rr_last_draw_q, rr_last_draw_d;
`endif

    logic       pick_probe;
    logic       pick_draw;
    logic [4:0] sel_col;
    logic [5:0] sel_row;
    logic       sel_in_range;

    // Pixel bits below the brick size only locate a pixel inside a brick.
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^{probe_x[4:0], probe_y[3:0], draw_x[4:0], draw_y[3:0],
                                 hit_x[4:0], hit_y[3:0]};

    function automatic logic [7:0] brick_addr(input logic [4:0] col, input logic [5:0] row);
        return 8'(32'(row) * COLS + 32'(col));
    endfunction

    function automatic logic brick_in_range(input logic [4:0] col, input logic [5:0] row);
        return (32'(col) < COLS) && (32'(row) < ROWS);
    endfunction

    // Requester selection: hit always wins, then probe versus draw.
    always_comb begin
        pick_probe = 1'b0;
        pick_draw  = 1'b0;
        if (!hit_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (probe_req && draw_req) begin
                pick_probe = rr_last_draw_q;
                pick_draw  = !rr_last_draw_q;
            end else begin
                pick_probe = probe_req;
                pick_draw  = draw_req;
            end
`else
            pick_probe = probe_req;
            pick_draw  = draw_req && !probe_req;
`endif
        end
        if (hit_req) begin
            sel_col = hit_x[9:5];
            sel_row = hit_y[9:4];
        end else if (pick_probe) begin
            sel_col = probe_x[9:5];
            sel_row = probe_y[9:4];
        end else begin
            sel_col = draw_x[9:5];
            sel_row = draw_y[9:4];
        end
        sel_in_range = brick_in_range(sel_col, sel_row);
    end

    // Next-state logic: grant in IDLE, read, capture health, optional write-back.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        addr_d     = addr_q;
        in_range_d = in_range_q;
        health_d   = health_q;
        bricks_d   = bricks_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_draw_d = rr_last_draw_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hit_req || pick_probe || pick_draw) begin
                    state_d    = ST_READ;
                    src_d      = hit_req ? SRC_HIT : (pick_probe ? SRC_PROBE : SRC_DRAW);
                    in_range_d = sel_in_range;
                    addr_d     = sel_in_range ? brick_addr(sel_col, sel_row) : 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    if (!hit_req) begin
                        rr_last_draw_d = pick_draw;
                    end
`endif
                end
            end
            ST_READ: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (src_q == SRC_HIT) begin
                    health_d = in_range_q ? mem_rdata : 2'd0;
                    state_d  = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                // Health 1 -> 0 destroys the brick; the counter never wraps below zero.
                if (in_range_q && health_q == 2'd1 && bricks_q != 8'd0) begin
                    bricks_d = bricks_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from the current state so reset silences them immediately.
    always_comb begin
        mem_addr  = 8'd0;
        probe_ack = 1'b0;
        draw_ack  = 1'b0;
        hit_ack   = 1'b0;
        rd_health = 2'd0;
        mem_we    = 1'b0;
        mem_wdata = 2'd0;
        case (state_q)
            ST_READ: begin
                mem_addr = addr_q;
            end
            ST_RESP: begin
                if (src_q == SRC_PROBE) begin
                    probe_ack = 1'b1;
                end
                if (src_q == SRC_DRAW) begin
                    draw_ack = 1'b1;
                end
                if (src_q != SRC_HIT) begin
                    rd_health = in_range_q ? mem_rdata : 2'd0;
                end
            end
            ST_WRITE: begin
                hit_ack  = 1'b1;
                mem_addr = addr_q;
                if (in_range_q && health_q != 2'd0) begin
                    mem_we    = 1'b1;
                    mem_wdata = health_q - 2'd1;
                end
            end
            default: begin
                mem_addr = 8'd0;
            end
        endcase
        bricks_left = bricks_q;
        all_cleared = (bricks_q == 8'd0);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_PROBE;
            addr_q     <= 8'd0;
            in_range_q <= 1'b0;
            health_q   <= 2'd0;
            bricks_q   <= 8'(TOTAL_BRICKS);
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_draw_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            in_range_q <= in_range_d;
            health_q   <= health_d;
            bricks_q   <= bricks_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_draw_q <= rr_last_draw_d;
`endif
        end
    end

endmodule

// File: tb/tb_brick_mem_arbiter.sv
// tb/tb_brick_mem_arbiter.sv - randomized self-checking bench for brick_mem_arbiter
module tb_brick_mem_arbiter;

    localparam int COLS  = 20;
    localparam int ROWS  = 8;
    localparam int TOTAL = 160;

    logic       clk;
    logic       resetn;
    logic       probe_req, draw_req, hit_req;
    logic [9:0] probe_x, probe_y, draw_x, draw_y, hit_x, hit_y;
    logic       probe_ack, draw_ack, hit_ack;
    logic [1:0] rd_health;
    logic [7:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [1:0] mem_wdata;
    logic       mem_we;
    logic [7:0] bricks_left;
    logic       all_cleared;
    logic       load_pulse;

    logic [1:0] env_mem [0:255];
    int         model_mem [0:255];
    int         model_left;
    bit         rr_last_draw;
    int         n_tests;
    int         n_fail;

    brick_mem_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .probe_req  (probe_req),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .probe_ack  (probe_ack),
        .draw_req   (draw_req),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_ack   (draw_ack),
        .rd_health  (rd_health),
        .hit_req    (hit_req),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .hit_ack    (hit_ack),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .bricks_left(bricks_left),
        .all_cleared(all_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] init_val(input int i);
        if (i == 42) return 2'd2;
        return 2'((i % 3) + 1);
    endfunction

    // Synchronous brick memory: data appears one cycle after the address.
    always @(posedge clk) begin
        if (load_pulse) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
        end else if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= env_mem[mem_addr];
    end

    function automatic bit m_in(input int x, input int y);
        return ((x >> 5) < COLS) && ((y >> 4) < ROWS);
    endfunction

    function automatic int m_addr(input int x, input int y);
        return (y >> 4) * COLS + (x >> 5);
    endfunction

    function automatic int m_health(input int x, input int y);
        return m_in(x, y) ? model_mem[m_addr(x, y)] : 0;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_hit(input int x, input int y);
        if (m_in(x, y) && model_mem[m_addr(x, y)] != 0) begin
            model_mem[m_addr(x, y)]--;
            if (model_mem[m_addr(x, y)] == 0 && model_left > 0) model_left--;
        end
    endtask

    task automatic run_round(input bit eh, input bit ep, input bit ed,
                             input int hx, input int hy, input int px, input int py,
                             input int dx, input int dy);
        int q[$];
        int cyc, nack, who, exp, a, ex, ey;
        bit exp_we;
        if (eh) q.push_back(0);
        if (ep && ed) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (rr_last_draw) begin q.push_back(1); q.push_back(2); end
            else begin q.push_back(2); q.push_back(1); end
`else
            q.push_back(1); q.push_back(2);
`endif
        end else if (ep) begin
            q.push_back(1);
        end else if (ed) begin
            q.push_back(2);
        end
        @(negedge clk);
        hit_req = eh;   hit_x = 10'(hx);   hit_y = 10'(hy);
        probe_req = ep; probe_x = 10'(px); probe_y = 10'(py);
        draw_req = ed;  draw_x = 10'(dx);  draw_y = 10'(dy);
        cyc = 0;
        while (q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            nack = int'(hit_ack) + int'(probe_ack) + int'(draw_ack);
            if (nack > 1) begin
                check("single_ack", nack, 1);
            end else if (nack == 0) begin
                check("idle_we", mem_we, 0);
                check("idle_health", rd_health, 0);
            end else begin
                who = hit_ack ? 0 : (probe_ack ? 1 : 2);
                check("grant_order", who, q[0]);
                exp = q.pop_front();
                if (exp == 0) begin
                    exp_we = m_in(hx, hy) && model_mem[m_addr(hx, hy)] != 0;
                    check("hit_we", mem_we, int'(exp_we));
                    if (exp_we) begin
                        a = m_addr(hx, hy);
                        check("hit_addr", mem_addr, a);
                        check("hit_wdata", mem_wdata, model_mem[a] - 1);
                    end
                    model_hit(hx, hy);
                end else begin
                    ex = (exp == 1) ? px : dx;
                    ey = (exp == 1) ? py : dy;
                    check("rd_health", rd_health, m_health(ex, ey));
                    check("read_we", mem_we, 0);
                    rr_last_draw = (exp == 2);
                end
                if (who == 0) hit_req = 1'b0;
                else if (who == 1) probe_req = 1'b0;
                else draw_req = 1'b0;
            end
        end
        if (q.size() != 0) check("round_timeout", q.size(), 0);
        hit_req = 1'b0; probe_req = 1'b0; draw_req = 1'b0;
        @(negedge clk);
        check("bricks_left", bricks_left, model_left);
        check("all_cleared", all_cleared, int'(model_left == 0));
    endtask

    task automatic run_cont(input int n);
        int cyc, seen, got, expw;
        @(negedge clk);
        probe_req = 1'b1; probe_x = 10'd64; probe_y = 10'd32;
        draw_req  = 1'b1; draw_x  = 10'd0;  draw_y  = 10'd16;
        seen = 0;
        cyc = 0;
        while (seen < n && cyc < 20 * n) begin
            @(negedge clk);
            cyc++;
            if (probe_ack || draw_ack) begin
                got = draw_ack ? 2 : 1;
`ifdef ARB_ROUND_ROBIN_EN
                expw = rr_last_draw ? 1 : 2;
`else
                expw = 1;
`endif
                check("cont_order", got, expw);
                check("cont_health", rd_health, (expw == 1) ? m_health(64, 32) : m_health(0, 16));
                rr_last_draw = (expw == 2);
                seen++;
            end
        end
        if (seen < n) check("cont_timeout", seen, n);
        probe_req = 1'b0;
        draw_req  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("cont_quiet", int'(probe_ack | draw_ack), 0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn = 1'b0; load_pulse = 1'b1;
        hit_req = 1'b0; probe_req = 1'b0; draw_req = 1'b0;
        hit_x = '0; hit_y = '0; probe_x = '0; probe_y = '0; draw_x = '0; draw_y = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = int'(init_val(i));
        model_left = TOTAL;
        rr_last_draw = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_probe_ack", probe_ack, 0);
        check("rst_draw_ack", draw_ack, 0);
        check("rst_hit_ack", hit_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rd_health", rd_health, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_bricks", bricks_left, TOTAL);
        check("rst_cleared", all_cleared, 0);
        load_pulse = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        // Probe at (64,32): brick 42, read latency of two cycles.
        probe_req = 1'b1; probe_x = 10'd64; probe_y = 10'd32;
        @(negedge clk);
        check("probe_read_addr", mem_addr, 42);
        check("probe_early_ack", probe_ack, 0);
        @(negedge clk);
        check("probe_ack", probe_ack, 1);
        check("probe_health", rd_health, 2);
        probe_req = 1'b0;
        @(negedge clk);
        check("probe_ack_pulse", probe_ack, 0);

        // Hit at (0,0) on a health-1 brick destroys it.
        hit_req = 1'b1; hit_x = 10'd0; hit_y = 10'd0;
        @(negedge clk);
        @(negedge clk);
        check("hit_early_ack", hit_ack, 0);
        check("hit_early_we", mem_we, 0);
        @(negedge clk);
        check("hit0_ack", hit_ack, 1);
        check("hit0_we", mem_we, 1);
        check("hit0_wdata", mem_wdata, 0);
        check("hit0_addr", mem_addr, 0);
        hit_req = 1'b0;
        model_hit(0, 0);
        @(negedge clk);
        check("hit0_bricks", bricks_left, 159);

        // Simultaneous hit, probe and draw.
        run_round(1, 1, 1, 32, 16, 128, 48, 300, 100);
        // Out-of-range hit and probe.
        run_round(1, 0, 0, 700, 0, 0, 0, 0, 0);
        run_round(0, 1, 0, 0, 0, 0, 200, 0, 0);

        // Reset asserted during WRITE of brick 3 (health 1) aborts the write.
        hit_req = 1'b1; hit_x = 10'd96; hit_y = 10'd0;
        repeat (3) @(negedge clk);
        check("wr_abort_pre_we", mem_we, 1);
        resetn = 1'b0;
        #1;
        check("wr_abort_we", mem_we, 0);
        check("wr_abort_ack", hit_ack, 0);
        check("wr_abort_addr", mem_addr, 0);
        check("wr_abort_bricks", bricks_left, TOTAL);
        hit_req = 1'b0;
        model_left = TOTAL;
        rr_last_draw = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_round(0, 1, 0, 0, 0, 96, 0, 0, 0);

        run_cont(6);

        for (int r = 0; r < 40; r++) begin
            bit eh, ep, ed;
            eh = 1'($urandom_range(0, 1));
            ep = 1'($urandom_range(0, 1));
            ed = 1'($urandom_range(0, 1));
            if (!eh && !ep && !ed) ep = 1'b1;
            run_round(eh, ep, ed,
                      int'($urandom_range(0, 700)), int'($urandom_range(0, 140)),
                      int'($urandom_range(0, 700)), int'($urandom_range(0, 140)),
                      int'($urandom_range(0, 700)), int'($urandom_range(0, 140)));
        end

        for (int i = 0; i < COLS * ROWS; i++) check("mem_image", env_mem[i], model_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/brick_mem_arbiter.md
BRICK_MEM_ARBITER -- requirements
Module: brick_mem_arbiter

Interface
REQ-001 SHALL have parameter COLS, default 20, bricks per row.
REQ-002 SHALL have parameter ROWS, default 8, brick rows.
REQ-003 SHALL have parameter TOTAL_BRICKS, default 160, reset value of bricks_left.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port probe_req  input  1  collision-probe read request, held until probe_ack.
REQ-007 SHALL have port probe_x, probe_y  input  10 each  probe pixel coordinate.
REQ-008 SHALL have port probe_ack  output  1  one-cycle pulse; rd_health valid for probe.
REQ-009 SHALL have port draw_req  input  1  renderer read request, held until draw_ack.
REQ-010 SHALL have port draw_x, draw_y  input  10 each  renderer pixel coordinate.
REQ-011 SHALL have port draw_ack  output  1  one-cycle pulse; rd_health valid for draw.
REQ-012 SHALL have port rd_health  output  2  health read for the acked requester; 0 otherwise.
REQ-013 SHALL have port hit_req  input  1  damage request, held until hit_ack.
REQ-014 SHALL have port hit_x, hit_y  input  10 each  pixel coordinate of damaged brick.
REQ-015 SHALL have port hit_ack  output  1  one-cycle pulse; damage complete.
REQ-016 SHALL have port mem_addr  output  8  brick memory address, row*COLS+col.
REQ-017 SHALL have port mem_rdata  input  2  memory read data, valid one cycle after mem_addr.
REQ-018 SHALL have port mem_wdata  output  2  write data.
REQ-019 SHALL have port mem_we  output  1  write enable, one cycle.
REQ-020 SHALL have port bricks_left  output  8  count of bricks with nonzero health.
REQ-021 SHALL have port all_cleared  output  1  high when bricks_left == 0.

Function
REQ-022 SHALL map pixel to brick as col = x[9:5], row = y[9:4]; col >= COLS or row >= ROWS is out of range.
REQ-023 SHALL implement states IDLE, READ, RESP, WRITE.
REQ-024 SHALL in IDLE grant one pending request per priority: hit > (probe vs draw per REQ-034/035); no request stays IDLE.
REQ-025 SHALL latch granted coordinates at grant edge and drive mem_addr from the latch in READ.
REQ-026 SHALL go READ -> RESP unconditionally; RESP samples mem_rdata (forced 0 if out of range).
REQ-027 SHALL for read grants pulse probe_ack/draw_ack with rd_health in RESP, then return to IDLE; read latency req-seen-in-IDLE cycle c -> ack in c+2.
REQ-028 SHALL for hit grants go RESP -> WRITE; in WRITE pulse hit_ack, and if health != 0 and in range, pulse mem_we with mem_wdata = health-1 at the latched address.
REQ-029 SHALL never write when health is 0 or out of range; hit_ack still pulses.
REQ-030 SHALL decrement bricks_left by 1 on a write of 0 (health 1 -> 0); saturate at 0.
REQ-031 SHALL not regrant in the cycle an ack is pulsed (one IDLE cycle minimum between grants).
REQ-032 SHALL hold non-granted requests pending without ack; requests dropped before grant are ignored.

Reset
REQ-033 SHALL on resetn low, immediately: state IDLE, all acks/mem_we 0, rd_health/mem_addr/mem_wdata 0, bricks_left = TOTAL_BRICKS; any in-flight write aborted.

Configuration
REQ-034 SHALL with ARB_ROUND_ROBIN_EN defined arbitrate probe/draw round-robin: last-served loses a tie; pointer resets to favour probe.
REQ-035 SHALL without ARB_ROUND_ROBIN_EN use fixed priority probe > draw.

Verification
REQ-036 SHALL test probe_req with (64,32), mem_rdata 2 -> mem_addr 42 in READ, probe_ack + rd_health 2 two cycles after request.
REQ-037 SHALL test hit_req (0,0), mem_rdata 1 -> mem_we, mem_wdata 0, addr 0 in WRITE; bricks_left 160 -> 159.
REQ-038 SHALL test hit, probe, draw raised same cycle -> order hit, probe, draw; with ARB_ROUND_ROBIN_EN continuous probe+draw alternate.
REQ-039 SHALL test hit_req (700,0) out of range -> hit_ack, no mem_we, bricks_left unchanged; probe at (0,200) -> rd_health 0.
REQ-040 SHALL test resetn low in WRITE -> no mem_we, state IDLE, bricks_left 160, next request served normally.
